fir_mac_engine: RTL and testbench

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_mac_engine_if.sv | 26 ++
 rtl/fir_coef_bank.sv | 48 ++++
 rtl/fir_mac_engine.sv | 142 ++++++++++++++
 tb/tb_fir_mac_engine.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, state encoding and arithmetic helpers for the FIR MAC engine.
package fir_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int DW_DEF    = 16;
    localparam int OW_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Full-precision product width plus headroom for NTAPS additions.
    function automatic int acc_width(input int dw, input int ntaps);
        return 2 * dw + $clog2(ntaps);
    endfunction

    // Clamp a sign-extended sum into the signed range of an ow-bit result.
    function automatic logic signed [63:0] sat_ow(input logic signed [63:0] sum, input int ow);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (ow - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample-in / result-out handshake bundle of the FIR MAC engine.
interface fir_mac_engine_if
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: host writes land in the shadow bank and
// are copied to the active bank only when a new sample starts.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NTAPS)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     commit,
    input  logic [$clog2(NTAPS)-1:0] raddr,
    output logic signed [DW-1:0]     rdata
);

    logic signed [DW-1:0] shadow_r [NTAPS];
    logic signed [DW-1:0] active_r [NTAPS];

    // Shadow bank: accepts host writes in any engine state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (we) begin
            shadow_r[waddr] <= $signed(wdata);
        end
    end

    // Active bank: snapshot of the shadow bank taken at sample acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                active_r[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NTAPS; i++) begin
                active_r[i] <= shadow_r[i];
            end
        end
    end

    assign rdata = active_r[raddr];

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR filter: one multiply-accumulate per clock over a circular
// delay line, saturated result presented on a valid/ready output.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [DW-1:0]            coef_wdata,
    input  logic                     clr,
    output logic                     busy,
    fir_mac_engine_if.slave          bus
);

    localparam int LW = $clog2(NTAPS);
    localparam int AW = acc_width(DW, NTAPS);

    fir_state_e           state_r;
    logic [LW-1:0]        wptr_r;
    logic [LW-1:0]        tap_r;
    logic signed [AW-1:0] acc_r;
    logic signed [DW-1:0] dline_r [NTAPS];
    logic                 m_valid_r;
    logic [OW-1:0]        m_data_r;
    logic                 busy_r;

    logic                   xfer_s;
    logic                   clr_s;
    logic [LW-1:0]          rd_idx_s;
    logic signed [DW-1:0]   coef_s;
    logic signed [DW-1:0]   samp_s;
    logic signed [2*DW-1:0] coef_ext_s;
    logic signed [2*DW-1:0] samp_ext_s;
    logic signed [2*DW-1:0] prod_s;
    logic signed [AW-1:0]   prod_ext_s;
    logic signed [AW-1:0]   acc_next_s;
    logic signed [63:0]     acc_wide_s;
    logic signed [63:0]     sat_s;

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_coef_bank (
        .clk    (ACLK),
        .rst    (ARESET),
        .we     (coef_we),
        .waddr  (coef_addr),
        .wdata  (coef_wdata),
        .commit (xfer_s),
        .raddr  (tap_r),
        .rdata  (coef_s)
    );

    // Handshake decode and the multiply-accumulate datapath.
    always_comb begin
        clr_s      = (state_r == ST_IDLE) && clr;
        xfer_s     = (state_r == ST_IDLE) && !clr && bus.s_valid;
        // Newest sample sits one slot behind the already-advanced write pointer.
        rd_idx_s   = wptr_r - LW'(1) - tap_r;
        samp_s     = dline_r[rd_idx_s];
        coef_ext_s = {{DW{coef_s[DW-1]}}, coef_s};
        samp_ext_s = {{DW{samp_s[DW-1]}}, samp_s};
        prod_s     = coef_ext_s * samp_ext_s;
        prod_ext_s = {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
        acc_next_s = acc_r + prod_ext_s;
        acc_wide_s = {{(64-AW){acc_next_s[AW-1]}}, acc_next_s};
        sat_s      = sat_ow(acc_wide_s, OW);
    end

    // Circular delay line and its write pointer.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wptr_r <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                dline_r[i] <= '0;
            end
        end else if (clr_s) begin
            wptr_r <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                dline_r[i] <= '0;
            end
        end else if (xfer_s) begin
            dline_r[wptr_r] <= $signed(bus.s_data);
            wptr_r          <= wptr_r + LW'(1);
        end
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r   <= ST_IDLE;
            tap_r     <= '0;
            acc_r     <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        acc_r   <= '0;
                        tap_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    tap_r <= tap_r + LW'(1);
                    if (tap_r == LW'(NTAPS - 1)) begin
                        m_data_r  <= OW'(sat_s);
                        m_valid_r <= 1'b1;
                        state_r   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = (state_r == ST_IDLE) && !clr;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine: directed samples push expected results,
// a negedge monitor pops and compares each accepted output.
module tb_fir_mac_engine;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = 3'd0;
    logic [15:0] coef_wdata = 16'd0;
    logic        clr = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int out_idx = 0;
    logic [31:0] exp_q [$];

    fir_mac_engine_if #(.DW(16), .OW(32)) bus ();

    fir_mac_engine #(.NTAPS(8), .DW(16), .OW(32)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .clr        (clr),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 ACLK = ~ACLK;

    // Monitor: every output accepted on the coming edge must match the queue head.
    always @(negedge ACLK) begin
        if (bus.m_valid && bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out[%0d]: unexpected result %h, none expected", out_idx, bus.m_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.m_data !== e) begin
                    errors++;
                    $display("FAIL out[%0d]: got %h expected %h", out_idx, bus.m_data, e);
                end
            end
            out_idx++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] v);
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = v;
        @(posedge ACLK); #1;
        coef_we = 1'b0;
    endtask

    task automatic coefs_ramp();
        for (int i = 0; i < 8; i++) write_coef(3'(i), 16'(i + 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.m_valid) && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [15:0] x, input logic [31:0] e, input bit push);
        int n = 0;
        while (!bus.s_ready && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 200) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            bus.s_valid = 1'b1;
            bus.s_data = x;
            if (push) exp_q.push_back(e);
            @(posedge ACLK); #1;
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic do_clr();
        wait_idle();
        clr = 1'b1;
        @(posedge ACLK); #1;
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 16'd0;
        bus.m_ready = 1'b1;
        #23 ARESET = 1'b0;
        @(posedge ACLK); #1;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", bus.m_data, 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Impulse response walks through the coefficients, then drops to zero.
        coefs_ramp();
        send(16'd1, 32'd1, 1'b1);
        for (int i = 2; i <= 9; i++) send(16'd0, (i <= 8) ? 32'(i) : 32'd0, 1'b1);

        // Positive saturation from the third output on.
        for (int i = 0; i < 8; i++) write_coef(3'(i), 16'h7FFF);
        do_clr();
        send(16'h7FFF, 32'h3FFF0001, 1'b1);
        send(16'h7FFF, 32'h7FFE0002, 1'b1);
        for (int i = 0; i < 6; i++) send(16'h7FFF, 32'h7FFFFFFF, 1'b1);

        // Negative saturation.
        do_clr();
        send(16'h8000, 32'hC0008000, 1'b1);
        send(16'h8000, 32'h80010000, 1'b1);
        for (int i = 0; i < 6; i++) send(16'h8000, 32'h80000000, 1'b1);

        // Backpressure: result must hold while m_ready is low.
        coefs_ramp();
        do_clr();
        bus.m_ready = 1'b0;
        send(16'd2, 32'd2, 1'b1);
        begin
            int n = 0;
            while (!bus.m_valid && n < 50) begin
                @(posedge ACLK); #1;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_m_valid", 32'(bus.m_valid), 32'd1);
            check("bp_m_data", bus.m_data, 32'd2);
            check("bp_s_ready", 32'(bus.s_ready), 32'd0);
        end
        @(posedge ACLK); #1;
        bus.m_ready = 1'b1;
        @(posedge ACLK); #1;
        check("bp_released_valid", 32'(bus.m_valid), 32'd0);
        check("bp_released_busy", 32'(busy), 32'd0);

        // Coefficient write mid-computation only affects the next sample.
        do_clr();
        send(16'd1, 32'd1, 1'b1);
        write_coef(3'd0, 16'd5);
        do_clr();
        send(16'd1, 32'd5, 1'b1);

        // clr wins over s_valid in the same idle cycle.
        write_coef(3'd0, 16'd1);
        wait_idle();
        bus.s_valid = 1'b1;
        bus.s_data = 16'd9;
        clr = 1'b1;
        #1;
        check("clr_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge ACLK); #1;
        clr = 1'b0;
        bus.s_valid = 1'b0;
        check("clr_no_xfer", 32'(busy), 32'd0);
        send(16'd3, 32'd3, 1'b1);

        // Reset in the middle of a computation abandons it.
        wait_idle();
        send(16'd7, 32'd0, 1'b0);
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        #2;
        ARESET = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_m_data", bus.m_data, 32'd0);
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge ACLK); #1;
        repeat (20) @(posedge ACLK);
        #1;
        check("mid_rst_no_valid", 32'(bus.m_valid), 32'd0);
        send(16'd1, 32'd0, 1'b1);
        send(16'd0, 32'd0, 1'b1);
        wait_idle();
        repeat (2) @(posedge ACLK);
        #1;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
